boot_rom_loader: RTL and testbench



---
 rtl/boot_loader_pkg.sv | 16 +
 rtl/boot_rom_loader_wr_skid.sv | 48 ++++
 rtl/boot_rom_loader.sv | 133 +++++++++++++
 tb/tb_boot_rom_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot ROM loader and the emu top level.
// boot_state_t : loader FSM states (IDLE, LOAD, HOLD).
// PROG_ADDR_W / PROG_ROM_SIZE : program memory geometry (4 KiB); emu also
// uses these to size the boot ROM.
package boot_loader_pkg;

  localparam int unsigned PROG_ADDR_W   = 12;
  localparam int unsigned PROG_ROM_SIZE = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } boot_state_t;

endpackage

// File: rtl/boot_rom_loader_wr_skid.sv
// loader_wr_skid: one-entry skid buffer between the ioctl byte stream and the
// program memory write port.
//   load/load_addr/load_data : byte to capture (already qualified by caller)
//   mem_wr_ready             : memory accepts a write this cycle
//   mem_wr_en/addr/data      : registered write request (mem_wr_en = pending)
//   ioctl_wait               : pending & ~mem_wr_ready
//   accept                   : write completes this cycle
//   drop                     : a load arrived while the entry could not free up
module loader_wr_skid #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              mem_wr_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data,
  output logic              ioctl_wait,
  output logic              accept,
  output logic              drop
);

  logic pending;

  assign mem_wr_en  = pending;
  assign accept     = pending & mem_wr_ready;
  assign ioctl_wait = pending & ~mem_wr_ready;
  assign drop       = load & pending & ~mem_wr_ready;

  // A new byte may be captured in the same cycle the held one drains.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else if (load && (!pending || mem_wr_ready)) begin
      pending     <= 1'b1;
      mem_wr_addr <= load_addr;
      mem_wr_data <= load_data;
    end else if (accept) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/boot_rom_loader.sv
// boot_rom_loader: copies the HPS ioctl download into CPU program memory and
// holds the CPU in reset during the transfer plus a settle period.
//   clk_sys, reset_n          : clock, async active-low reset
//   ioctl_download/wr/addr/dout, ioctl_wait : hps_io download interface
//   mem_wr_en/addr/data, mem_wr_ready       : program memory write port
//   cpu_reset_req             : hold the T80 in reset
//   copy_in_progress          : high in LOAD or HOLD (drives LED_USER)
//   byte_count, checksum      : writes and mod-256 sum of the current/last load
//   overflow                  : sticky, a byte was dropped (range or overrun)
module boot_rom_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = PROG_ADDR_W,
  parameter int unsigned ROM_SIZE    = PROG_ROM_SIZE,
  parameter int unsigned HOLD_CYCLES = 256,
  parameter int unsigned HOLD_W      = 9
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [26:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data,
  input  logic              mem_wr_ready,
  output logic              cpu_reset_req,
  output logic              copy_in_progress,
  output logic [ADDR_W:0]   byte_count,
  output logic [7:0]        checksum,
  output logic              overflow
);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  boot_state_t       state;
  logic [HOLD_W-1:0] hold_cnt;

  logic in_range;
  logic skid_load;
  logic out_of_range;
  logic accept;
  logic drop;

  assign in_range     = ioctl_addr < 27'(ROM_SIZE);
  assign skid_load    = (state == LOAD) & ioctl_wr & in_range;
  assign out_of_range = (state == LOAD) & ioctl_wr & ~in_range;

  loader_wr_skid #(
    .ADDR_W (ADDR_W)
  ) u_wr_skid (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .load         (skid_load),
    .load_addr    (ioctl_addr[ADDR_W-1:0]),
    .load_data    (ioctl_dout),
    .mem_wr_ready (mem_wr_ready),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .ioctl_wait   (ioctl_wait),
    .accept       (accept),
    .drop         (drop)
  );

  // Status updates come first so that the LOAD-entry clears below win.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      hold_cnt         <= HOLD_INIT;
      cpu_reset_req    <= 1'b1;
      copy_in_progress <= 1'b0;
      byte_count       <= '0;
      checksum         <= '0;
      overflow         <= 1'b0;
    end else begin
      if (accept) begin
        if (byte_count != '1)
          byte_count <= byte_count + CNT_ONE;
        checksum <= checksum + mem_wr_data;
      end
      if (out_of_range || drop)
        overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (ioctl_download) begin
            state            <= LOAD;
            cpu_reset_req    <= 1'b1;
            copy_in_progress <= 1'b1;
            byte_count       <= '0;
            checksum         <= '0;
            overflow         <= 1'b0;
          end else begin
            // Power-on hold: request drops on the edge the count reaches 0.
            if (hold_cnt != '0)
              hold_cnt <= hold_cnt - HOLD_ONE;
            cpu_reset_req <= (hold_cnt > HOLD_ONE);
          end
        end
        LOAD: begin
          if (!ioctl_download && !mem_wr_en) begin
            state    <= HOLD;
            hold_cnt <= HOLD_INIT;
          end
        end
        HOLD: begin
          if (ioctl_download) begin
            state      <= LOAD;
            byte_count <= '0;
            checksum   <= '0;
            overflow   <= 1'b0;
          end else if (hold_cnt == HOLD_ONE) begin
            state            <= IDLE;
            hold_cnt         <= '0;
            cpu_reset_req    <= 1'b0;
            copy_in_progress <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HOLD_ONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_rom_loader.sv
module tb_boot_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        mem_wr_en;
  logic [11:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic        mem_wr_ready;
  logic        cpu_reset_req;
  logic        copy_in_progress;
  logic [12:0] byte_count;
  logic [7:0]  checksum;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  boot_rom_loader #(
    .ADDR_W      (12),
    .ROM_SIZE    (4096),
    .HOLD_CYCLES (256),
    .HOLD_W      (9)
  ) dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .ioctl_download   (ioctl_download),
    .ioctl_wr         (ioctl_wr),
    .ioctl_addr       (ioctl_addr),
    .ioctl_dout       (ioctl_dout),
    .ioctl_wait       (ioctl_wait),
    .mem_wr_en        (mem_wr_en),
    .mem_wr_addr      (mem_wr_addr),
    .mem_wr_data      (mem_wr_data),
    .mem_wr_ready     (mem_wr_ready),
    .cpu_reset_req    (cpu_reset_req),
    .copy_in_progress (copy_in_progress),
    .byte_count       (byte_count),
    .checksum         (checksum),
    .overflow         (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Steps until cpu_reset_req falls; gives up at 1000 steps.
  task automatic steps_to_release(output int n, output logic saw_idle_copy);
    n = 0;
    saw_idle_copy = 1'b0;
    while (cpu_reset_req && n < 1000) begin
      step();
      n++;
    end
    saw_idle_copy = copy_in_progress;
  endtask

  // Strobe one byte; the write request must appear exactly one cycle later.
  task automatic strobe(input logic [26:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    step();
    ioctl_wr = 1'b0;
  endtask

  logic [7:0] prog [4] = '{8'h3E, 8'h41, 8'hD3, 8'h00};
  int   n;
  logic cp;
  logic copy_seen;

  initial begin
    reset_n        = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    mem_wr_ready   = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_req",      cpu_reset_req, 1);
    chk("rst_copy",     copy_in_progress, 0);
    chk("rst_wr_en",    mem_wr_en, 0);
    chk("rst_wr_addr",  mem_wr_addr, 0);
    chk("rst_count",    byte_count, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_wait",     ioctl_wait, 0);

    // Power-on hold, watching that copy_in_progress never rises.
    step();
    reset_n = 1'b1;
    n = 0;
    copy_seen = 1'b0;
    while (cpu_reset_req && n < 1000) begin
      step();
      n++;
      copy_seen |= copy_in_progress;
    end
    chk("por_hold_len", n, 256);
    chk("por_copy", copy_seen, 0);
    step();
    chk("por_req_stays_low", cpu_reset_req, 0);

    // Four-byte download with memory always ready.
    ioctl_download = 1'b1;
    step();
    chk("load_copy", copy_in_progress, 1);
    chk("load_req",  cpu_reset_req, 1);
    for (int i = 0; i < 4; i++) begin
      chk("pre_strobe_wr_en", mem_wr_en, 0);
      strobe(27'(i), prog[i]);
      chk("wr_en",   mem_wr_en, 1);
      chk("wr_addr", mem_wr_addr, i);
      chk("wr_data", mem_wr_data, prog[i]);
      step();
      chk("wr_en_drop", mem_wr_en, 0);
    end
    chk("dl4_count",    byte_count, 4);
    chk("dl4_checksum", checksum, 8'h52);
    chk("dl4_overflow", overflow, 0);
    ioctl_download = 1'b0;
    step();
    chk("hold_copy", copy_in_progress, 1);
    steps_to_release(n, cp);
    chk("hold_len",  n, 256);
    chk("hold_done_copy", cp, 0);

    // Back-pressure: memory not ready for 5 cycles after the strobe.
    ioctl_download = 1'b1;
    step();
    chk("reload_count", byte_count, 4'd4 - 4'd4);
    mem_wr_ready = 1'b0;
    strobe(27'd5, 8'hA5);
    chk("bp_wr_en", mem_wr_en, 1);
    chk("bp_wait_c1", ioctl_wait, 1);
    for (int i = 2; i <= 5; i++) begin
      step();
      chk("bp_wait", ioctl_wait, 1);
    end
    chk("bp_count_held", byte_count, 0);
    mem_wr_ready = 1'b1;
    #1;
    chk("bp_wait_release", ioctl_wait, 0);
    chk("bp_wr_addr", mem_wr_addr, 5);
    step();
    chk("bp_wr_en_done", mem_wr_en, 0);
    chk("bp_count", byte_count, 1);
    chk("bp_checksum", checksum, 8'hA5);

    // Out of range byte at ROM_SIZE, then the last in-range address.
    strobe(27'h1000, 8'hFF);
    chk("oor_wr_en", mem_wr_en, 0);
    chk("oor_overflow", overflow, 1);
    chk("oor_count", byte_count, 1);
    chk("oor_checksum", checksum, 8'hA5);
    strobe(27'hFFF, 8'h01);
    chk("top_wr_en", mem_wr_en, 1);
    chk("top_wr_addr", mem_wr_addr, 12'hFFF);
    step();
    chk("top_count", byte_count, 2);
    chk("top_checksum", checksum, 8'hA6);
    chk("oor_sticky", overflow, 1);

    // Restart the download at HOLD cycle 100.
    ioctl_download = 1'b0;
    step();
    for (int i = 0; i < 99; i++) step();
    chk("mid_hold_req", cpu_reset_req, 1);
    ioctl_download = 1'b1;
    step();
    chk("restart_copy", copy_in_progress, 1);
    chk("restart_count", byte_count, 0);
    chk("restart_checksum", checksum, 0);
    chk("restart_overflow", overflow, 0);
    strobe(27'd7, 8'h10);
    chk("restart_wr_addr", mem_wr_addr, 7);
    step();
    chk("restart_count1", byte_count, 1);
    ioctl_download = 1'b0;
    step();
    steps_to_release(n, cp);
    chk("restart_hold_len", n, 256);

    // Strobe while ioctl_wait is high: byte dropped, overflow set.
    ioctl_download = 1'b1;
    step();
    mem_wr_ready = 1'b0;
    strobe(27'd1, 8'h11);
    strobe(27'd2, 8'h22);
    chk("drop_overflow", overflow, 1);
    chk("drop_keep_addr", mem_wr_addr, 1);
    chk("drop_keep_data", mem_wr_data, 8'h11);
    mem_wr_ready = 1'b1;
    step();
    chk("drop_count", byte_count, 1);
    chk("drop_checksum", checksum, 8'h11);

    // Async reset with a byte pending.
    mem_wr_ready = 1'b0;
    strobe(27'd3, 8'h33);
    chk("pre_rst_pending", mem_wr_en, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_wr_en", mem_wr_en, 0);
    chk("arst_count", byte_count, 0);
    chk("arst_checksum", checksum, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_req", cpu_reset_req, 1);
    chk("arst_copy", copy_in_progress, 0);
    chk("arst_wait", ioctl_wait, 0);
    step();
    reset_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1);
  end

endmodule
